// File: rtl/bram_pkg.sv
// Shared definitions for the true dual-port block RAM.
// Holds the read-during-write mode constants, the clear-FSM state encoding
// and the helper that derives the byte-lane count from the data width.
package bram_pkg;

    // Read-during-write behaviour on the same port.
    localparam int RD_FIRST = 0;
    localparam int WR_FIRST = 1;

    // Power-up clear sequencer states.
    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_t;

    // One byte-write enable per 8-bit lane.
    function automatic int calc_be_w(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/bram_clear_fsm.sv
// Zero-fill sequencer for the dual-port RAM.
// After reset it walks every address once, one per clock, presenting a
// write strobe and address that the top muxes onto port A. busy stays high
// until the last address has been written.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   busy        - clear sequence in progress
//   clr_we      - write strobe for the clear data (zero)
//   clr_addr    - address being cleared this cycle
module bram_clear_fsm
    import bram_pkg::*;
#(
    parameter int ADDR_W         = 14,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    clr_state_t      state;
    logic [ADDR_W:0] count;
    logic [ADDR_W:0] count_next;

    // The extra counter bit flags the terminal count, so the last address
    // is detected without the counter wrapping back to zero.
    assign count_next = count + 1'b1;

    // Single-process FSM; busy is a registered output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            if (CLEAR_ON_RESET != 0) begin
                state <= CLEAR;
                busy  <= 1'b1;
            end else begin
                state <= READY;
                busy  <= 1'b0;
            end
        end else begin
            case (state)
                CLEAR: begin
                    count <= count_next;
                    if (count_next[ADDR_W]) begin
                        state <= READY;
                        busy  <= 1'b0;
                    end
                end
                READY: begin
                    busy <= 1'b0;
                end
                default: begin
                    state <= READY;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign clr_we   = busy;
    assign clr_addr = count[ADDR_W-1:0];

endmodule

// File: rtl/tdp_bram_param.sv
// Parameterised true dual-port block RAM with byte-write enables.
// Both ports share one clock. Every accepted access returns read data after
// 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1), flagged by valid_x. An
// optional post-reset clear zero-fills the array through port A while busy
// is high; user requests are ignored during that time.
//
// Ports:
//   clk, rst_n                    - clock, asynchronous active-low reset
//   en_x, we_x, addr_x, din_x     - port x request (x = a, b)
//   dout_x, valid_x               - port x read data and its qualifier
//   busy                          - clear sequence running
//   collision                     - same-address conflict seen last cycle
module tdp_bram_param
    import bram_pkg::*;
#(
    parameter  int DATA_W         = 32,
    parameter  int ADDR_W         = 14,
    parameter  int RD_MODE        = RD_FIRST,
    parameter  int OUT_REG        = 0,
    parameter  int CLEAR_ON_RESET = 1,
    localparam int BE_W           = calc_be_w(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_a,
    input  logic [BE_W-1:0]   we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] din_a,
    output logic [DATA_W-1:0] dout_a,
    output logic              valid_a,
    input  logic              en_b,
    input  logic [BE_W-1:0]   we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] din_b,
    output logic [DATA_W-1:0] dout_b,
    output logic              valid_b,
    output logic              busy,
    output logic              collision
);

    localparam int DEPTH = 2 ** ADDR_W;

    (* ram_style = "block" *) logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    logic              acc_a, acc_b;
    logic [BE_W-1:0]   wr_we_a, wr_we_b;
    logic [ADDR_W-1:0] wr_addr_a;
    logic [DATA_W-1:0] wr_din_a;

    logic [DATA_W-1:0] old_a, old_b;
    logic [DATA_W-1:0] merged_a, merged_b;
    logic [DATA_W-1:0] rd_next_a, rd_next_b;

    logic [DATA_W-1:0] q1_a, q1_b;
    logic              v1_a, v1_b;

    bram_clear_fsm #(
        .ADDR_W         (ADDR_W),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear (
        .clk      (clk),
        .rst_n    (rst_n),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign acc_a = en_a && !busy;
    assign acc_b = en_b && !busy;

    // Clear writes take over port A; user writes are only possible when
    // the sequencer is idle, so the two never compete.
    always_comb begin
        if (clr_we) begin
            wr_we_a   = '1;
            wr_addr_a = clr_addr;
            wr_din_a  = '0;
        end else begin
            wr_we_a   = acc_a ? we_a : '0;
            wr_addr_a = addr_a;
            wr_din_a  = din_a;
        end
        wr_we_b = acc_b ? we_b : '0;
    end

    // Port A is written after port B inside each lane, so on a lane both
    // ports write to the same word, port A's byte is the one kept.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_W; i++) begin
            if (wr_we_b[i]) begin
                mem[addr_b][8*i +: 8] <= din_b[8*i +: 8];
            end
            if (wr_we_a[i]) begin
                mem[wr_addr_a][8*i +: 8] <= wr_din_a[8*i +: 8];
            end
        end
    end

    // Write-first read data: the stored word with this port's own written
    // lanes replaced by the incoming bytes.
    always_comb begin
        old_a    = mem[addr_a];
        old_b    = mem[addr_b];
        merged_a = old_a;
        merged_b = old_b;
        for (int i = 0; i < BE_W; i++) begin
            if (we_a[i]) begin
                merged_a[8*i +: 8] = din_a[8*i +: 8];
            end
            if (we_b[i]) begin
                merged_b[8*i +: 8] = din_b[8*i +: 8];
            end
        end
        rd_next_a = (RD_MODE == WR_FIRST) ? merged_a : old_a;
        rd_next_b = (RD_MODE == WR_FIRST) ? merged_b : old_b;
    end

    // First read stage plus the collision flag. Data only moves on an
    // accepted access so dout holds its last value otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1_a      <= '0;
            q1_b      <= '0;
            v1_a      <= 1'b0;
            v1_b      <= 1'b0;
            collision <= 1'b0;
        end else begin
            v1_a      <= acc_a;
            v1_b      <= acc_b;
            collision <= acc_a && acc_b && (addr_a == addr_b) && ((|we_a) || (|we_b));
            if (acc_a) begin
                q1_a <= rd_next_a;
            end
            if (acc_b) begin
                q1_b <= rd_next_b;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] q2_a, q2_b;
            logic              v2_a, v2_b;

            // Optional second stage; valid travels with the data.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q2_a <= '0;
                    q2_b <= '0;
                    v2_a <= 1'b0;
                    v2_b <= 1'b0;
                end else begin
                    v2_a <= v1_a;
                    v2_b <= v1_b;
                    if (v1_a) begin
                        q2_a <= q1_a;
                    end
                    if (v1_b) begin
                        q2_b <= q1_b;
                    end
                end
            end

            assign dout_a  = q2_a;
            assign dout_b  = q2_b;
            assign valid_a = v2_a;
            assign valid_b = v2_b;
        end else begin : g_no_out_reg
            assign dout_a  = q1_a;
            assign dout_b  = q1_b;
            assign valid_a = v1_a;
            assign valid_b = v1_b;
        end
    endgenerate

endmodule

// File: tb/tb_tdp_bram_param.sv
// Testbench for tdp_bram_param.
// Two instances share identical stimulus: one read-first without output
// register, one write-first with output register. A word-level model of the
// memory, the clear window and the read latency predicts every output.
module tb_tdp_bram_param;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int BW    = 4;
    localparam int DEPTH = 16;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          en_a, en_b;
    logic [BW-1:0] we_a, we_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] din_a, din_b;

    logic [DW-1:0] rf_dout_a, rf_dout_b, wf_dout_a, wf_dout_b;
    logic          rf_valid_a, rf_valid_b, wf_valid_a, wf_valid_b;
    logic          rf_busy, wf_busy, rf_collision, wf_collision;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    logic [DW-1:0] mm [DEPTH];
    bit            busy_m;
    int            clr_cnt;
    logic [DW-1:0] exp_d0 [2];
    bit            exp_v0 [2];
    bit            known0 [2];
    logic [DW-1:0] exp_d1 [2];
    bit            exp_v1 [2];
    bit            known1 [2];
    logic [DW-1:0] st_d   [2];
    bit            st_v   [2];
    bit            st_k   [2];
    bit            exp_col;

    logic [AW-1:0] r_aa, r_ab;
    int            ncyc;

    always #5 clk = ~clk;

    tdp_bram_param #(
        .DATA_W(DW), .ADDR_W(AW), .RD_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(1)
    ) u_dut_rf (
        .clk(clk), .rst_n(rst_n),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a),
        .dout_a(rf_dout_a), .valid_a(rf_valid_a),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b),
        .dout_b(rf_dout_b), .valid_b(rf_valid_b),
        .busy(rf_busy), .collision(rf_collision)
    );

    tdp_bram_param #(
        .DATA_W(DW), .ADDR_W(AW), .RD_MODE(1), .OUT_REG(1), .CLEAR_ON_RESET(1)
    ) u_dut_wf (
        .clk(clk), .rst_n(rst_n),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a),
        .dout_a(wf_dout_a), .valid_a(wf_valid_a),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b),
        .dout_b(wf_dout_b), .valid_b(wf_valid_b),
        .busy(wf_busy), .collision(wf_collision)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mergeWord(input logic [DW-1:0] old, input logic [DW-1:0] din,
                                                 input logic [BW-1:0] we);
        logic [DW-1:0] w;
        w = old;
        for (int i = 0; i < BW; i++) begin
            if (we[i]) w[8*i +: 8] = din[8*i +: 8];
        end
        return w;
    endfunction

    task automatic compareAll();
        checkOutput("rf_valid_a", rf_valid_a, exp_v0[0]);
        checkOutput("rf_valid_b", rf_valid_b, exp_v0[1]);
        checkOutput("wf_valid_a", wf_valid_a, exp_v1[0]);
        checkOutput("wf_valid_b", wf_valid_b, exp_v1[1]);
        if (known0[0]) checkOutput("rf_dout_a", rf_dout_a, exp_d0[0]);
        if (known0[1]) checkOutput("rf_dout_b", rf_dout_b, exp_d0[1]);
        if (known1[0]) checkOutput("wf_dout_a", wf_dout_a, exp_d1[0]);
        if (known1[1]) checkOutput("wf_dout_b", wf_dout_b, exp_d1[1]);
        checkOutput("rf_busy", rf_busy, busy_m);
        checkOutput("wf_busy", wf_busy, busy_m);
        checkOutput("rf_collision", rf_collision, exp_col);
        checkOutput("wf_collision", wf_collision, exp_col);
    endtask

    // After any reset the clear runs to completion before a request can be
    // accepted, so the model treats memory as all-zero from this point.
    task automatic modelReset();
        busy_m  = 1'b1;
        clr_cnt = 0;
        exp_col = 1'b0;
        for (int i = 0; i < DEPTH; i++) mm[i] = '0;
        for (int p = 0; p < 2; p++) begin
            exp_d0[p] = '0; exp_v0[p] = 1'b0; known0[p] = 1'b1;
            exp_d1[p] = '0; exp_v1[p] = 1'b0; known1[p] = 1'b1;
            st_d[p]   = '0; st_v[p]   = 1'b0; st_k[p]   = 1'b1;
        end
    endtask

    // Advance the model by one clock using the inputs sampled at that edge.
    task automatic modelStep();
        bit            acc [2];
        logic [DW-1:0] oldw [2];
        logic [DW-1:0] neww [2];
        bit            col;
        acc[0]  = en_a && !busy_m;
        acc[1]  = en_b && !busy_m;
        oldw[0] = mm[addr_a];
        oldw[1] = mm[addr_b];
        neww[0] = mergeWord(oldw[0], din_a, we_a);
        neww[1] = mergeWord(oldw[1], din_b, we_b);
        col     = acc[0] && acc[1] && (addr_a == addr_b) && ((we_a != 0) || (we_b != 0));
        for (int p = 0; p < 2; p++) begin
            exp_v1[p] = st_v[p];
            if (st_v[p]) begin
                exp_d1[p] = st_d[p];
                known1[p] = st_k[p];
            end
            st_v[p] = acc[p];
            if (acc[p]) begin
                st_d[p] = neww[p];
                st_k[p] = !col;
            end
            exp_v0[p] = acc[p];
            if (acc[p]) begin
                exp_d0[p] = oldw[p];
                known0[p] = !col;
            end
        end
        if (busy_m) mm[clr_cnt] = '0;
        if (acc[1]) mm[addr_b] = mergeWord(mm[addr_b], din_b, we_b);
        if (acc[0]) mm[addr_a] = mergeWord(mm[addr_a], din_a, we_a);
        if (busy_m) begin
            clr_cnt++;
            if (clr_cnt == DEPTH) busy_m = 1'b0;
        end
        exp_col = col;
    endtask

    task automatic applyStimulus(input logic ea, input logic [BW-1:0] wa, input logic [AW-1:0] aa,
                                 input logic [DW-1:0] da, input logic eb, input logic [BW-1:0] wb,
                                 input logic [AW-1:0] ab, input logic [DW-1:0] db);
        en_a = ea; we_a = wa; addr_a = aa; din_a = da;
        en_b = eb; we_b = wb; addr_b = ab; din_b = db;
        @(posedge clk);
        #1;
        modelStep();
        compareAll();
    endtask

    // Outputs must read as reset values immediately and across clock edges.
    task automatic doReset(input int hold);
        en_a = 1'b0; we_a = '0; en_b = 1'b0; we_b = '0;
        rst_n = 1'b0;
        #1;
        modelReset();
        compareAll();
        repeat (hold) begin
            @(posedge clk);
            #1;
            compareAll();
        end
        rst_n = 1'b1;
    endtask

    initial begin
        en_a = 1'b0; we_a = '0; addr_a = '0; din_a = '0;
        en_b = 1'b0; we_b = '0; addr_b = '0; din_b = '0;
        #3;
        doReset(2);

        // Interrupt the clear at count 9, with gated write attempts meanwhile.
        repeat (9) applyStimulus(1'b1, 4'hF, 4'd9, 32'hCAFEF00D, 1'b1, 4'hF, 4'd12, 32'h12345678);
        doReset(3);

        // Full clear window while port A keeps trying to write address 2.
        ncyc = 0;
        while (rf_busy === 1'b1 && ncyc < 40) begin
            applyStimulus(1'b1, 4'hF, 4'd2, 32'hDEADBEEF, 1'b0, 4'h0, 4'd0, 32'h0);
            ncyc++;
        end
        checkOutput("clear_len", ncyc, 32'd16);

        // Every word reads zero after the clear.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 4'h0, 4'(i), 32'h0, 1'b1, 4'h0, 4'(DEPTH - 1 - i), 32'h0);
        end
        applyStimulus(1'b1, 4'h0, 4'd2, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0);
        checkOutput("gated_wr", rf_dout_a, 32'h0);

        // Byte-lane write merging.
        applyStimulus(1'b1, 4'hF, 4'd5, 32'hAABBCCDD, 1'b0, 4'h0, 4'd0, 32'h0);
        applyStimulus(1'b1, 4'b0010, 4'd5, 32'h00001100, 1'b0, 4'h0, 4'd0, 32'h0);
        applyStimulus(1'b1, 4'h0, 4'd5, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0);
        checkOutput("byte_merge", rf_dout_a, 32'hAABB11DD);

        // Read-during-write: read-first sees old data, write-first new data.
        applyStimulus(1'b1, 4'hF, 4'd7, 32'h1, 1'b0, 4'h0, 4'd0, 32'h0);
        applyStimulus(1'b1, 4'hF, 4'd7, 32'h2, 1'b0, 4'h0, 4'd0, 32'h0);
        checkOutput("rd_first", rf_dout_a, 32'h1);
        checkOutput("rd_first_valid", rf_valid_a, 32'h1);
        applyStimulus(1'b0, 4'h0, 4'd0, 32'h0, 1'b0, 4'h0, 4'd0, 32'h0);
        checkOutput("wr_first_lat2", wf_dout_a, 32'h2);
        checkOutput("wr_first_valid", wf_valid_a, 32'h1);
        checkOutput("rd_first_valid_drop", rf_valid_a, 32'h0);

        // Same-address write collision, port A wins.
        applyStimulus(1'b1, 4'hF, 4'd3, 32'h11111111, 1'b1, 4'hF, 4'd3, 32'h22222222);
        checkOutput("col_pulse", rf_collision, 32'h1);
        applyStimulus(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'h0, 4'd3, 32'h0);
        checkOutput("col_one_cycle", rf_collision, 32'h0);
        checkOutput("col_winner", rf_dout_b, 32'h11111111);

        // Randomised traffic with frequent address overlap.
        for (int k = 0; k < 400; k++) begin
            r_aa = 4'($urandom_range(0, 15));
            r_ab = ($urandom_range(0, 3) == 0) ? r_aa : 4'($urandom_range(0, 15));
            applyStimulus($urandom_range(0, 3) != 0, ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0,
                          r_aa, $urandom,
                          $urandom_range(0, 3) != 0, ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0,
                          r_ab, $urandom);
            if (k == 200) begin
                // Reset while reads are in flight: no stale valid afterwards.
                doReset(1);
                repeat (DEPTH) applyStimulus(1'b1, 4'hF, 4'd1, 32'h5A5A5A5A, 1'b1, 4'h0, 4'd1, 32'h0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
